wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order writeback stage and a
//  multi-cycle execution unit (mul/div). Multi-cycle results are queued in a small FIFO and
//  drained into idle write-port cycles. If a result waits too long, or the FIFO fills, the
//  block requests a one-cycle W-stage freeze from the hazard unit to force a drain.
// PARAMETERS
//  XLEN          32  data width of write port and results
//  REG_AW        5   register index width
//  DEPTH         2   multi-cycle result FIFO entries (power of two, >=2)
//  STARVE_LIMIT  4   cycles a non-empty FIFO head may wait before a stall is requested
// PORTS
//  clk         in   1       clock; all state on rising edge
//  rst         in   1       asynchronous, active-low reset
//  RegWriteW   in   1       W-stage write enable
//  RDW         in   REG_AW  W-stage destination register
//  ResultW     in   XLEN    W-stage result (from result mux)
//  mc_valid    in   1       multi-cycle unit offers a result
//  mc_rd       in   REG_AW  its destination register
//  mc_data     in   XLEN    its result
//  mc_ready    out  1       FIFO can accept (= !full)
//  RegWriteR   out  1       register-file write enable
//  RDR         out  REG_AW  register-file write address
//  WriteDataR  out  XLEN    register-file write data
//  StallWB     out  1       registered request: hold W-stage regs this cycle
//  mc_pending  out  1       FIFO non-empty (for hazard/scoreboard use)
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, pointers/count 0, starve_cnt 0, StallWB 0; RegWriteR 0,
//   RDR 0, WriteDataR 0, mc_ready 1, mc_pending 0.
//  Enqueue: mc_valid && mc_ready at posedge stores {mc_rd, mc_data}. mc_rd==0 is accepted and
//   discarded (never stored). mc_ready depends only on registered count (no pass-through when
//   full, even if a dequeue occurs that cycle).
//  Min latency mc_valid -> RegWriteR is 1 cycle; no same-cycle bypass.
//  Write-port grant (combinational from registered state and inputs):
//   1. StallWB==1: FIFO head granted if non-empty; W-stage write suppressed (hazard unit
//      holds W regs, so the instruction retries next cycle).
//   2. else RegWriteW && RDW!=0: W-stage granted (RDR=RDW, WriteDataR=ResultW).
//   3. else FIFO non-empty: head granted, dequeued at posedge.
//   4. else RegWriteR=0; RDR/WriteDataR driven 0.
//  RegWriteW with RDW==0 never uses the port (x0 writes dropped).
//  Simultaneous enqueue and dequeue: both take effect, count unchanged.
//  Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
//  starve_cnt: cleared when FIFO empty or head dequeued; else +1, saturating at STARVE_LIMIT.
//  StallWB next = !StallWB && mc_pending_next &&
//   (starve_cnt_next >= STARVE_LIMIT || count_next == DEPTH).
//   StallWB is never high two cycles in a row; a stall cycle always dequeues one entry.
//  Ordering: no reordering or RAW checking here; scoreboard owns WAW/RAW against mc_pending.
//  Reset mid-operation discards queued results and any pending stall immediately.
// TESTING
//  1. Idle FIFO, RegWriteW=1 RDW=5 ResultW=0xA5 -> same cycle RegWriteR=1 RDR=5 WD=0xA5, StallWB=0.
//  2. mc_valid rd=7 data=0x1234, W idle -> next cycle RegWriteR=1 RDR=7 WD=0x1234, mc_pending->0.
//  3. Enqueue rd=3 under continuous W writes -> StallWB=1 exactly once after 4 waiting cycles;
//     that cycle RDR=3; W write retried next cycle.
//  4. Two enqueues (rd=1,2) with W busy -> mc_ready=0, StallWB next cycle, entries drain in order 1,2.
//  5. mc_rd=0 enqueue, RegWriteW=1 RDW=0 -> no RegWriteR pulse, mc_pending stays 0.
//  6. rst low with 2 queued and StallWB=1 -> all outputs reset asynchronously; after release no stale write.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order W stage and a multi-cycle unit.
// Multi-cycle results wait in a small FIFO and drain into idle cycles or forced W-stage freezes.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              mc_valid,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [XLEN-1:0]   mc_data,
  output logic              mc_ready,
  output logic              RegWriteR,
  output logic [REG_AW-1:0] RDR,
  output logic [XLEN-1:0]   WriteDataR,
  output logic              StallWB,
  output logic              mc_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] LIMIT = STV_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [STV_W-1:0]   starve_cnt;
  logic [STV_W-1:0]   starve_next;
  logic               stall_next;
  logic               enq;
  logic               deq;

  // Readiness comes only from the registered count, so a full FIFO never accepts,
  // even in a cycle where it also dequeues.
  assign mc_ready   = (count != FULL);
  assign mc_pending = (count != '0);
  assign head       = mem[rd_ptr];

  // x0 results are handshaken but never stored.
  assign enq = mc_valid && mc_ready && (mc_rd != '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    RegWriteR  = 1'b0;
    RDR        = '0;
    WriteDataR = '0;
    deq        = 1'b0;
    // The grant is combinational, so it is gated while reset is asserted to keep the port quiet.
    if (rst) begin
      if (StallWB) begin
        if (mc_pending) begin
          RegWriteR  = 1'b1;
          RDR        = head.rd;
          WriteDataR = head.data;
          deq        = 1'b1;
        end
      end else if (RegWriteW && (RDW != '0)) begin
        RegWriteR  = 1'b1;
        RDR        = RDW;
        WriteDataR = ResultW;
      end else if (mc_pending) begin
        RegWriteR  = 1'b1;
        RDR        = head.rd;
        WriteDataR = head.data;
        deq        = 1'b1;
      end
    end
  end

  always_comb begin
    count_next = count;
    if (enq && !deq) begin
      count_next = count + CNT_W'(1);
    end else if (deq && !enq) begin
      count_next = count - CNT_W'(1);
    end
  end

  // The age counter belongs to whichever entry is at the head; a new head starts from zero.
  always_comb begin
    starve_next = starve_cnt;
    if (!mc_pending || deq) begin
      starve_next = '0;
    end else if (starve_cnt < LIMIT) begin
      starve_next = starve_cnt + STV_W'(1);
    end
  end

  // A freeze always dequeues, so it cannot be requested two cycles running.
  assign stall_next = !StallWB && (count_next != '0) &&
                      ((starve_next >= LIMIT) || (count_next == FULL));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      StallWB    <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count      <= count_next;
      starve_cnt <= starve_next;
      StallWB    <= stall_next;
    end
  end

  // NOTE: the storage array is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{rd: mc_rd, data: mc_data};
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wb_port_arbiter;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWriteW;
  logic [REG_AW-1:0] RDW;
  logic [XLEN-1:0]   ResultW;
  logic              mc_valid;
  logic [REG_AW-1:0] mc_rd;
  logic [XLEN-1:0]   mc_data;
  logic              mc_ready;
  logic              RegWriteR;
  logic [REG_AW-1:0] RDR;
  logic [XLEN-1:0]   WriteDataR;
  logic              StallWB;
  logic              mc_pending;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(
    .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_ready(mc_ready), .RegWriteR(RegWriteR), .RDR(RDR), .WriteDataR(WriteDataR),
    .StallWB(StallWB), .mc_pending(mc_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pending results in a queue, the head's wait time, and the freeze flag.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } ent_t;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              ready;
    logic              pending;
    logic              stall;
    logic              deq;
  } exp_t;

  ent_t q[$];
  int   head_wait = 0;
  bit   m_stall   = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    e         = '0;
    e.ready   = (q.size() < DEPTH);
    e.pending = (q.size() != 0);
    e.stall   = m_stall;
    if (m_stall) begin
      if (q.size() != 0) begin
        e.we = 1'b1; e.rd = q[0].rd; e.data = q[0].data; e.deq = 1'b1;
      end
    end else if (RegWriteW && RDW != 0) begin
      e.we = 1'b1; e.rd = RDW; e.data = ResultW;
    end else if (q.size() != 0) begin
      e.we = 1'b1; e.rd = q[0].rd; e.data = q[0].data; e.deq = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      head_wait = 0;
      m_stall   = 1'b0;
    end else begin
      exp_t e;
      bit   had_head;
      bit   took;
      e        = model_out();
      had_head = (q.size() != 0);
      took     = mc_valid && e.ready;
      if (e.deq) void'(q.pop_front());
      if (took && mc_rd != 0) q.push_back('{rd: mc_rd, data: mc_data});
      if (!had_head || e.deq) head_wait = 0;
      else if (head_wait < STARVE_LIMIT) head_wait++;
      m_stall = !m_stall && (q.size() != 0) &&
                (head_wait >= STARVE_LIMIT || q.size() == DEPTH);
    end
  end

  // Compare process: outputs are checked mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      e       = '0;
      e.ready = 1'b1;
    end else begin
      e = model_out();
    end
    check("model RegWriteR",  64'(RegWriteR),  64'(e.we));
    check("model RDR",        64'(RDR),        64'(e.rd));
    check("model WriteDataR", 64'(WriteDataR), 64'(e.data));
    check("model mc_ready",   64'(mc_ready),   64'(e.ready));
    check("model mc_pending", 64'(mc_pending), 64'(e.pending));
    check("model StallWB",    64'(StallWB),    64'(e.stall));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_idle();
    RegWriteW = 1'b0; RDW = '0; ResultW = '0;
    mc_valid  = 1'b0; mc_rd = '0; mc_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    mid();
    check("reset RegWriteR", 64'(RegWriteR), 64'd0);
    check("reset mc_ready",  64'(mc_ready),  64'd1);
    check("reset StallWB",   64'(StallWB),   64'd0);
    tick();
    rst = 1'b1;

    // 1: W-stage write passes straight through with an idle FIFO.
    RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hA5;
    mid();
    check("t1 RegWriteR", 64'(RegWriteR),  64'd1);
    check("t1 RDR",       64'(RDR),        64'd5);
    check("t1 WD",        64'(WriteDataR), 64'hA5);
    check("t1 StallWB",   64'(StallWB),    64'd0);
    tick();
    set_idle();

    // 2: multi-cycle result written the cycle after it is offered.
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h1234;
    mid();
    check("t2 no bypass", 64'(RegWriteR), 64'd0);
    tick();
    set_idle();
    mid();
    check("t2 RegWriteR", 64'(RegWriteR),  64'd1);
    check("t2 RDR",       64'(RDR),        64'd7);
    check("t2 WD",        64'(WriteDataR), 64'h1234);
    tick();
    mid();
    check("t2 drained", 64'(mc_pending), 64'd0);
    tick();

    // 3: starvation under continuous W writes forces exactly one freeze.
    RegWriteW = 1'b1; RDW = 5'd9; ResultW = 32'h900;
    mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'h33;
    tick();
    mc_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      mid();
      check("t3 waiting no stall", 64'(StallWB), 64'd0);
      check("t3 waiting W owns",   64'(RDR),     64'd9);
      tick();
    end
    mid();
    check("t3 stall",     64'(StallWB),    64'd1);
    check("t3 stall RDR", 64'(RDR),        64'd3);
    check("t3 stall WD",  64'(WriteDataR), 64'h33);
    tick();
    mid();
    check("t3 single stall", 64'(StallWB),    64'd0);
    check("t3 W retried",    64'(RDR),        64'd9);
    check("t3 W data",       64'(WriteDataR), 64'h900);
    tick();
    set_idle();
    tick();

    // 4: filling the FIFO forces a freeze; a full FIFO refuses even while dequeuing.
    RegWriteW = 1'b1; RDW = 5'd9; ResultW = 32'h901;
    mc_valid = 1'b1; mc_rd = 5'd1; mc_data = 32'h11;
    tick();
    mc_rd = 5'd2; mc_data = 32'h22;
    mid();
    check("t4 ready before full", 64'(mc_ready), 64'd1);
    tick();
    mc_rd = 5'd13; mc_data = 32'h99;
    mid();
    check("t4 full not ready", 64'(mc_ready), 64'd0);
    check("t4 full stall",     64'(StallWB),  64'd1);
    check("t4 first drain",    64'(RDR),      64'd1);
    tick();
    mc_valid = 1'b0;
    mid();
    check("t4 no back-to-back", 64'(StallWB), 64'd0);
    check("t4 W granted",       64'(RDR),     64'd9);
    tick();
    for (int i = 4; i <= 6; i++) begin
      mid();
      check("t4 waiting no stall", 64'(StallWB), 64'd0);
      tick();
    end
    mid();
    check("t4 second stall", 64'(StallWB),    64'd1);
    check("t4 second drain", 64'(RDR),        64'd2);
    check("t4 second data",  64'(WriteDataR), 64'h22);
    tick();
    mid();
    check("t4 refused entry absent", 64'(mc_pending), 64'd0);
    tick();
    set_idle();

    // 5: x0 writes from either source never reach the port.
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'hDEAD;
    RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'hBEEF;
    mid();
    check("t5 x0 no write", 64'(RegWriteR), 64'd0);
    check("t5 x0 ready",    64'(mc_ready),  64'd1);
    tick();
    set_idle();
    mid();
    check("t5 x0 no write after", 64'(RegWriteR),  64'd0);
    check("t5 x0 not queued",     64'(mc_pending), 64'd0);
    tick();

    // 6: asynchronous reset with a full FIFO and a pending freeze.
    RegWriteW = 1'b1; RDW = 5'd9; ResultW = 32'h902;
    mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h44;
    tick();
    mc_rd = 5'd6; mc_data = 32'h66;
    tick();
    mc_valid = 1'b0;
    mid();
    check("t6 stall before reset", 64'(StallWB), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6 async RegWriteR",  64'(RegWriteR),  64'd0);
    check("t6 async RDR",        64'(RDR),        64'd0);
    check("t6 async WD",         64'(WriteDataR), 64'd0);
    check("t6 async StallWB",    64'(StallWB),    64'd0);
    check("t6 async mc_ready",   64'(mc_ready),   64'd1);
    check("t6 async mc_pending", 64'(mc_pending), 64'd0);
    tick();
    set_idle();
    tick();
    rst = 1'b1;
    mid();
    check("t6 no stale write", 64'(RegWriteR), 64'd0);
    tick();
    mid();
    check("t6 still quiet", 64'(RegWriteR), 64'd0);
    tick();

    // 7: simultaneous enqueue and dequeue keeps the count and the order.
    mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hA0;
    tick();
    mc_rd = 5'd11; mc_data = 32'hB0;
    mid();
    check("t7 head out",  64'(RDR),      64'd10);
    check("t7 ready",     64'(mc_ready), 64'd1);
    tick();
    mc_valid = 1'b0;
    mid();
    check("t7 next out",  64'(RDR),        64'd11);
    check("t7 next data", 64'(WriteDataR), 64'hB0);
    check("t7 no stall",  64'(StallWB),    64'd0);
    tick();
    mid();
    check("t7 drained", 64'(mc_pending), 64'd0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
